// File: rtl/ethernet_hdr_parser_fifo.sv
// Ethernet header parser that snoops a 64-bit write stream, decodes an optional
// 802.1Q tag, and queues one parsed header per frame in a first-word-fall-through FIFO.
module ethernet_hdr_parser_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_IQ_BITS = 3,
  parameter int INPUT_ARBITER_STAGE_NUM = 2,
  parameter int HDR_FIFO_DEPTH_BITS = 2,
  parameter logic [15:0] VLAN_TPID = 16'h8100,
  parameter int VLAN_EN = 1,
  parameter logic [CTRL_WIDTH-1:0] IO_QUEUE_STAGE_NUM = '1,
  parameter int IOQ_SRC_PORT_POS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [CTRL_WIDTH-1:0]  in_ctrl,
  input  logic                   in_wr,
  output logic                   hdr_vld,
  input  logic                   hdr_rd,
  output logic [47:0]            hdr_dst_mac,
  output logic [47:0]            hdr_src_mac,
  output logic [15:0]            hdr_ethertype,
  output logic                   hdr_vlan_vld,
  output logic [2:0]             hdr_vlan_pcp,
  output logic [11:0]            hdr_vlan_id,
  output logic [NUM_IQ_BITS-1:0] hdr_src_port,
  output logic                   hdr_fifo_full,
  output logic [7:0]             runt_count,
  output logic [7:0]             drop_count
);

  localparam int DEPTH   = 1 << HDR_FIFO_DEPTH_BITS;
  localparam int ENTRY_W = 48 + 48 + 16 + 1 + 3 + 12 + NUM_IQ_BITS;
  localparam logic [HDR_FIFO_DEPTH_BITS:0] FULL_COUNT = {1'b1, {HDR_FIFO_DEPTH_BITS{1'b0}}};

  typedef enum logic [1:0] {
    READ_WORD_1,
    READ_WORD_2,
    READ_WORD_3,
    WAIT_EOP
  } state_t;

  state_t state, state_next;

  logic [47:0]            da_q;
  logic [15:0]            sa_hi_q;
  logic [31:0]            sa_lo_q;
  logic [15:0]            tci_q;
  logic [NUM_IQ_BITS-1:0] src_port_q;

  logic is_mod_hdr, is_eop, data_wr;
  logic push, push_ok, pop, runt_inc, drop_inc;
  logic [ENTRY_W-1:0] push_entry, head;

  logic [ENTRY_W-1:0]             mem [DEPTH];
  logic [HDR_FIFO_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic [HDR_FIFO_DEPTH_BITS:0]   count;

  // Compatibility-only parameter; referenced here so it is not flagged as dead.
  logic unused_params;
  assign unused_params = (INPUT_ARBITER_STAGE_NUM != 0);

  assign is_mod_hdr = (in_ctrl == IO_QUEUE_STAGE_NUM);
  assign is_eop     = (in_ctrl != '0);
  assign data_wr    = in_wr && !is_mod_hdr;

  always_comb begin
    state_next = state;
    push       = 1'b0;
    push_entry = '0;
    runt_inc   = 1'b0;
    if (data_wr) begin
      case (state)
        READ_WORD_1: begin
          if (is_eop) runt_inc = 1'b1;
          else        state_next = READ_WORD_2;
        end
        READ_WORD_2: begin
          if (VLAN_EN != 0 && in_data[31:16] == VLAN_TPID) begin
            if (is_eop) begin
              runt_inc   = 1'b1;
              state_next = READ_WORD_1;
            end else begin
              state_next = READ_WORD_3;
            end
          end else begin
            push       = 1'b1;
            push_entry = {da_q, sa_hi_q, in_data[63:32], in_data[31:16],
                          1'b0, 3'b000, 12'h000, src_port_q};
            state_next = is_eop ? READ_WORD_1 : WAIT_EOP;
          end
        end
        READ_WORD_3: begin
          push       = 1'b1;
          push_entry = {da_q, sa_hi_q, sa_lo_q, in_data[63:48],
                        1'b1, tci_q[15:13], tci_q[11:0], src_port_q};
          state_next = is_eop ? READ_WORD_1 : WAIT_EOP;
        end
        WAIT_EOP: begin
          if (is_eop) state_next = READ_WORD_1;
        end
        default: state_next = READ_WORD_1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= READ_WORD_1;
      da_q       <= '0;
      sa_hi_q    <= '0;
      sa_lo_q    <= '0;
      tci_q      <= '0;
      src_port_q <= '0;
    end else begin
      state <= state_next;
      if (in_wr && is_mod_hdr)
        src_port_q <= in_data[IOQ_SRC_PORT_POS +: NUM_IQ_BITS];
      if (data_wr && state == READ_WORD_1 && !is_eop) begin
        da_q    <= in_data[63:16];
        sa_hi_q <= in_data[15:0];
      end
      if (data_wr && state == READ_WORD_2) begin
        sa_lo_q <= in_data[63:32];
        tci_q   <= in_data[15:0];
      end
    end
  end

  // A full FIFO still accepts a push when the head is popped on the same edge.
  assign pop      = hdr_rd && (count != '0);
  assign push_ok  = push && (count != FULL_COUNT || pop);
  assign drop_inc = push && !push_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      runt_count <= '0;
      drop_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (runt_inc && runt_count != 8'hFF) runt_count <= runt_count + 8'd1;
      if (drop_inc && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  assign hdr_vld       = (count != '0);
  assign hdr_fifo_full = (count == FULL_COUNT);
  assign head          = hdr_vld ? mem[rd_ptr] : '0;
  assign {hdr_dst_mac, hdr_src_mac, hdr_ethertype, hdr_vlan_vld,
          hdr_vlan_pcp, hdr_vlan_id, hdr_src_port} = head;

endmodule
